// File: rtl/vga_pattern_gen_if.sv
// Pixel-side bus of the VGA pattern generator: pacing/pattern controls in,
// aligned sync, blank, coordinate and colour out.
interface vga_pattern_gen_if #(
  parameter int unsigned CW    = 1,
  parameter int unsigned CNT_W = 12
);
  logic              i_en;
  logic [1:0]        i_mode;
  logic [3*CW-1:0]   i_solid;
  logic              o_hsync;
  logic              o_vsync;
  logic              o_blank;
  logic [CNT_W-1:0]  o_x;
  logic [CNT_W-1:0]  o_y;
  logic              o_frame_start;
  logic [CW-1:0]     o_red;
  logic [CW-1:0]     o_grn;
  logic [CW-1:0]     o_blu;

  modport master (
    output i_en, i_mode, i_solid,
    input  o_hsync, o_vsync, o_blank, o_x, o_y, o_frame_start, o_red, o_grn, o_blu
  );

  modport slave (
    input  i_en, i_mode, i_solid,
    output o_hsync, o_vsync, o_blank, o_x, o_y, o_frame_start, o_red, o_grn, o_blu
  );
endinterface

// File: rtl/vga_pattern_gen.sv
// Parametrised VGA timing and test-pattern generator: h/v counters gated by a
// pixel enable, one output register stage carrying sync, blank, coords and colour.
module vga_pattern_gen #(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned H_FP     = 16,
  parameter int unsigned H_SYNC   = 96,
  parameter int unsigned H_BP     = 48,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned V_FP     = 10,
  parameter int unsigned V_SYNC   = 2,
  parameter int unsigned V_BP     = 33,
  parameter bit          SYNC_POL = 1'b0,
  parameter int unsigned CW       = 1,
  parameter int unsigned CNT_W    = 12,
  parameter int unsigned NUM_BARS = 8,
  parameter int unsigned CHK_LOG2 = 5,
  parameter int unsigned GRAD_SH  = 6
) (
  input logic              i_clk,
  input logic              i_rst_n,
  vga_pattern_gen_if.slave bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned BAR_W   = H_ACTIVE / NUM_BARS;

  localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0] HS_START = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0] HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0] VS_START = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0] VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CNT_W-1:0] BAR_LAST = CNT_W'(BAR_W - 1);
  localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_BARS - 1);
  localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

  logic [CNT_W-1:0]  h_q, v_q, bar_px_q, bar_idx_q;
  logic [1:0]        mode_q;
  logic [3*CW-1:0]   solid_q;

  logic              h_wrap_c, frame_end_c, active_c, hs_on_c, vs_on_c, chk_c;
  logic [2:0]        bar_col_c;
  logic [CW-1:0]     grad_c, red_c, grn_c, blu_c;

  assign h_wrap_c    = (h_q == H_LAST);
  assign frame_end_c = h_wrap_c && (v_q == V_LAST);
  assign active_c    = (h_q < H_ACT) && (v_q < V_ACT);
  assign hs_on_c     = (h_q >= HS_START) && (h_q < HS_END);
  assign vs_on_c     = (v_q >= VS_START) && (v_q < VS_END);
  assign chk_c       = h_q[CHK_LOG2] ^ v_q[CHK_LOG2];
  assign bar_col_c   = bar_idx_q[2:0];
  assign grad_c      = CW'(h_q >> GRAD_SH);

  // Raster counters plus the incremental bar tracker; bar_idx saturates so
  // remainder pixels at the right edge extend the last bar.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h_q       <= '0;
      v_q       <= '0;
      bar_px_q  <= '0;
      bar_idx_q <= '0;
      mode_q    <= '0;
      solid_q   <= '0;
    end else if (bus.i_en) begin
      if (h_wrap_c) begin
        h_q       <= '0;
        bar_px_q  <= '0;
        bar_idx_q <= '0;
        v_q       <= (v_q == V_LAST) ? '0 : v_q + ONE;
      end else begin
        h_q <= h_q + ONE;
        if (bar_px_q == BAR_LAST) begin
          bar_px_q <= '0;
          if (bar_idx_q != IDX_LAST) bar_idx_q <= bar_idx_q + ONE;
        end else begin
          bar_px_q <= bar_px_q + ONE;
        end
      end
      // Pattern selection only changes on the frame boundary.
      if (frame_end_c) begin
        mode_q  <= bus.i_mode;
        solid_q <= bus.i_solid;
      end
    end
  end

  // Colour of the current counter position, forced black outside the active area.
  always_comb begin
    red_c = '0;
    grn_c = '0;
    blu_c = '0;
    case (mode_q)
      2'd0: begin
        red_c = {CW{bar_col_c[2]}};
        grn_c = {CW{bar_col_c[1]}};
        blu_c = {CW{bar_col_c[0]}};
      end
      2'd1: begin
        red_c = {CW{chk_c}};
        grn_c = {CW{chk_c}};
        blu_c = {CW{chk_c}};
      end
      2'd2: begin
        red_c = grad_c;
        grn_c = grad_c;
        blu_c = grad_c;
      end
      default: {red_c, grn_c, blu_c} = solid_q;
    endcase
    if (!active_c) begin
      red_c = '0;
      grn_c = '0;
      blu_c = '0;
    end
  end

  // Single output stage keeps every output aligned one enable behind the counters.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      bus.o_hsync       <= ~SYNC_POL;
      bus.o_vsync       <= ~SYNC_POL;
      bus.o_blank       <= 1'b1;
      bus.o_x           <= '0;
      bus.o_y           <= '0;
      bus.o_frame_start <= 1'b0;
      bus.o_red         <= '0;
      bus.o_grn         <= '0;
      bus.o_blu         <= '0;
    end else if (bus.i_en) begin
      bus.o_hsync       <= hs_on_c ? SYNC_POL : ~SYNC_POL;
      bus.o_vsync       <= vs_on_c ? SYNC_POL : ~SYNC_POL;
      bus.o_blank       <= ~active_c;
      bus.o_x           <= h_q;
      bus.o_y           <= v_q;
      bus.o_frame_start <= (h_q == '0) && (v_q == '0);
      bus.o_red         <= red_c;
      bus.o_grn         <= grn_c;
      bus.o_blu         <= blu_c;
    end else begin
      bus.o_frame_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: a small-raster instance and a default 640x480
// instance checked every clock against a raster-position model.
module tb_vga_pattern_gen;

  typedef struct {
    int ha, hfp, hsw, hbp, va, vfp, vsw, vbp, pol, cw, nb, chk, gsh;
  } cfg_t;

  typedef struct {
    int hs, vs, blank, fs, x, y, r, g, b;
  } pix_t;

  logic clk;
  logic rst_n;
  bit   en_v;
  int   mode_v;
  int   sola, solb;
  bit   chk_on;

  int checks = 0;
  int errors = 0;

  vga_pattern_gen_if #(.CW(2), .CNT_W(12)) ifa ();
  vga_pattern_gen_if #(.CW(1), .CNT_W(12)) ifb ();

  assign ifa.i_en    = en_v;
  assign ifa.i_mode  = 2'(mode_v);
  assign ifa.i_solid = 6'(sola);
  assign ifb.i_en    = en_v;
  assign ifb.i_mode  = 2'(mode_v);
  assign ifb.i_solid = 3'(solb);

  vga_pattern_gen #(
    .H_ACTIVE(64), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(20), .V_FP(2), .V_SYNC(2), .V_BP(3),
    .SYNC_POL(1'b1), .CW(2), .CNT_W(12), .NUM_BARS(6), .CHK_LOG2(2), .GRAD_SH(2)
  ) u_dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifa)
  );

  vga_pattern_gen #(.CW(1), .CNT_W(12)) u_dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .bus(ifb)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic cfg_t get_cfg(int d);
    cfg_t c;
    if (d == 0) c = '{64, 4, 8, 4, 20, 2, 2, 3, 1, 2, 6, 2, 2};
    else        c = '{640, 16, 96, 48, 480, 10, 2, 33, 0, 1, 8, 5, 6};
    return c;
  endfunction

  // Expected output for raster position (x,y) under a frame's latched mode/solid.
  function automatic pix_t model(cfg_t c, int x, int y, int mode, int solid);
    pix_t p;
    int ones, idx, col, w;
    bit act;
    ones    = (1 << c.cw) - 1;
    act     = (x < c.ha) && (y < c.va);
    p.x     = x;
    p.y     = y;
    p.fs    = (x == 0 && y == 0) ? 1 : 0;
    p.blank = act ? 0 : 1;
    p.hs    = (x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hsw) ? c.pol : 1 - c.pol;
    p.vs    = (y >= c.va + c.vfp && y < c.va + c.vfp + c.vsw) ? c.pol : 1 - c.pol;
    p.r = 0; p.g = 0; p.b = 0;
    case (mode)
      0: begin
        idx = x / (c.ha / c.nb);
        if (idx > c.nb - 1) idx = c.nb - 1;
        col = idx % 8;
        p.r = ((col >> 2) & 1) != 0 ? ones : 0;
        p.g = ((col >> 1) & 1) != 0 ? ones : 0;
        p.b = (col & 1) != 0 ? ones : 0;
      end
      1: begin
        w = ((x >> c.chk) ^ (y >> c.chk)) & 1;
        p.r = w != 0 ? ones : 0;
        p.g = p.r;
        p.b = p.r;
      end
      2: begin
        p.r = (x >> c.gsh) & ones;
        p.g = p.r;
        p.b = p.r;
      end
      default: begin
        p.r = (solid >> (2 * c.cw)) & ones;
        p.g = (solid >> c.cw) & ones;
        p.b = solid & ones;
      end
    endcase
    if (!act) begin
      p.r = 0; p.g = 0; p.b = 0;
    end
    return p;
  endfunction

  function automatic pix_t reset_pix(cfg_t c);
    pix_t p;
    p = '{1 - c.pol, 1 - c.pol, 1, 0, 0, 0, 0, 0, 0};
    return p;
  endfunction

  function automatic pix_t rd(int d);
    pix_t p;
    if (d == 0) begin
      p = '{int'(ifa.o_hsync), int'(ifa.o_vsync), int'(ifa.o_blank), int'(ifa.o_frame_start),
            int'(ifa.o_x), int'(ifa.o_y), int'(ifa.o_red), int'(ifa.o_grn), int'(ifa.o_blu)};
    end else begin
      p = '{int'(ifb.o_hsync), int'(ifb.o_vsync), int'(ifb.o_blank), int'(ifb.o_frame_start),
            int'(ifb.o_x), int'(ifb.o_y), int'(ifb.o_red), int'(ifb.o_grn), int'(ifb.o_blu)};
    end
    return p;
  endfunction

  task automatic check(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic timeout(string name);
    checks++;
    errors++;
    $display("FAIL %s: wait bound expired, got no event expected one", name);
  endtask

  task automatic cmp_pix(string nm, pix_t a, pix_t e);
    check({nm, ".hsync"}, a.hs, e.hs);
    check({nm, ".vsync"}, a.vs, e.vs);
    check({nm, ".blank"}, a.blank, e.blank);
    check({nm, ".frame_start"}, a.fs, e.fs);
    check({nm, ".x"}, a.x, e.x);
    check({nm, ".y"}, a.y, e.y);
    check({nm, ".red"}, a.r, e.r);
    check({nm, ".grn"}, a.g, e.g);
    check({nm, ".blu"}, a.b, e.b);
  endtask

  // Per-clock scoreboard: raster position advances by one pixel per enabled edge.
  int   mx[2], my[2], fmode[2], fsol[2];
  pix_t exp_p[2];

  always begin : cmp_proc
    bit   s_en, s_rst;
    int   s_mode;
    int   s_sol[2];
    cfg_t c;
    int   ht, vt;
    @(posedge clk);
    s_en = en_v; s_rst = rst_n; s_mode = mode_v; s_sol[0] = sola; s_sol[1] = solb;
    #1;
    for (int d = 0; d < 2; d++) begin
      c  = get_cfg(d);
      ht = c.ha + c.hfp + c.hsw + c.hbp;
      vt = c.va + c.vfp + c.vsw + c.vbp;
      if (!s_rst) begin
        mx[d] = 0; my[d] = 0; fmode[d] = 0; fsol[d] = 0;
        exp_p[d] = reset_pix(c);
      end else if (s_en) begin
        exp_p[d] = model(c, mx[d], my[d], fmode[d], fsol[d]);
        if (mx[d] == ht - 1 && my[d] == vt - 1) begin
          fmode[d] = s_mode;
          fsol[d]  = s_sol[d];
        end
        mx[d]++;
        if (mx[d] == ht) begin
          mx[d] = 0;
          my[d] = (my[d] == vt - 1) ? 0 : my[d] + 1;
        end
      end else begin
        exp_p[d].fs = 0;
      end
      if (chk_on) cmp_pix(d == 0 ? "a" : "b", rd(d), exp_p[d]);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no completion expected finish before 1ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    cfg_t c1, c6;
    pix_t p;
    int   n;
    rst_n = 1'b0; en_v = 1'b0; mode_v = 0; sola = 0; solb = 0; chk_on = 1'b1;

    // Hand-computed points pinning the model to the default raster.
    c1 = get_cfg(1);
    c6 = c1; c6.nb = 6;
    p = model(c1, 79, 0, 0, 0);   check("pin bar x79 rgb", p.r*4 + p.g*2 + p.b, 0);
    p = model(c1, 80, 0, 0, 0);   check("pin bar x80 rgb", p.r*4 + p.g*2 + p.b, 1);
    p = model(c1, 320, 0, 0, 0);  check("pin bar x320 rgb", p.r*4 + p.g*2 + p.b, 4);
    p = model(c1, 639, 5, 0, 0);  check("pin bar x639 rgb", p.r*4 + p.g*2 + p.b, 7);
    p = model(c1, 640, 0, 0, 0);  check("pin x640 blank", p.blank*8 + p.r*4 + p.g*2 + p.b, 8);
    p = model(c1, 655, 0, 0, 0);  check("pin hsync x655", p.hs, 1);
    p = model(c1, 656, 0, 0, 0);  check("pin hsync x656", p.hs, 0);
    p = model(c1, 751, 0, 0, 0);  check("pin hsync x751", p.hs, 0);
    p = model(c1, 752, 0, 0, 0);  check("pin hsync x752", p.hs, 1);
    p = model(c1, 10, 490, 0, 0); check("pin vsync y490", p.vs, 0);
    p = model(c1, 10, 492, 0, 0); check("pin vsync y492", p.vs, 1);
    p = model(c6, 529, 0, 0, 0);  check("pin 6bar x529", p.r*4 + p.g*2 + p.b, 4);
    p = model(c6, 530, 0, 0, 0);  check("pin 6bar x530", p.r*4 + p.g*2 + p.b, 5);
    p = model(c6, 639, 0, 0, 0);  check("pin 6bar x639", p.r*4 + p.g*2 + p.b, 5);
    p = model(c1, 0, 0, 1, 0);    check("pin chk 0,0", p.r, 0);
    p = model(c1, 32, 0, 1, 0);   check("pin chk 32,0", p.r, 1);
    p = model(c1, 32, 32, 1, 0);  check("pin chk 32,32", p.r, 0);
    p = model(c1, 5, 5, 3, 2);    check("pin solid grn", p.r*4 + p.g*2 + p.b, 2);

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Continuous enable; mode rotates mid-frame so successive frames latch all four.
    en_v = 1'b1;
    for (int i = 0; i < 8700; i++) begin
      if (i % 700 == 350) begin
        mode_v = (mode_v + 1) % 4;
        sola   = $urandom_range(0, 63);
        solb   = $urandom_range(0, 7);
      end
      @(negedge clk);
    end

    // Random pixel-enable pacing with one long stall mid-line.
    for (int i = 0; i < 4000; i++) begin
      en_v = ($urandom_range(0, 1) == 1);
      if (i % 500 == 0) mode_v = $urandom_range(0, 3);
      if (i == 1000) begin
        en_v = 1'b0;
        repeat (10) @(negedge clk);
      end
      @(negedge clk);
    end

    // Asynchronous reset in the middle of a line.
    en_v = 1'b1;
    n = 0;
    while (!(ifa.o_x == 12'd30 && ifa.o_y == 12'd10) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) timeout("reach a(30,10)");
    #2 rst_n = 1'b0;
    mode_v = 1;
    #1;
    check("rst b.hsync", int'(ifb.o_hsync), 1);
    check("rst b.vsync", int'(ifb.o_vsync), 1);
    check("rst a.hsync", int'(ifa.o_hsync), 0);
    check("rst a.blank", int'(ifa.o_blank), 1);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("post-rst a.x", int'(ifa.o_x), 0);
    check("post-rst a.y", int'(ifa.o_y), 0);
    check("post-rst a.fs", int'(ifa.o_frame_start), 1);
    check("post-rst b.fs", int'(ifb.o_frame_start), 1);
    check("post-rst b.rgb", int'({ifb.o_red, ifb.o_grn, ifb.o_blu}), 0);
    @(negedge clk);
    check("post-rst a.fs clear", int'(ifa.o_frame_start), 0);
    check("post-rst b.x", int'(ifb.o_x), 1);

    // Solid colour requested mid-frame takes effect from the next (0,0).
    mode_v = 3; sola = 6'b00_11_00; solb = 3'b010;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ifa.o_frame_start != 1'b1 && n < 3000);
    if (n >= 3000) timeout("a next frame start");
    check("solid a(0,0) red", int'(ifa.o_red), 0);
    check("solid a(0,0) grn", int'(ifa.o_grn), 3);
    check("solid a(0,0) blu", int'(ifa.o_blu), 0);
    repeat (2200) @(negedge clk);

    chk_on = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_pattern_gen.md
Name: vga_pattern_gen

Overview:
Parametrised VGA test-pattern generator with horizontal/vertical timing, sync and blanking generation in one clock domain. It drives a pixel-enable-gated counter pair and produces aligned sync, blank, coordinate and colour outputs. Four selectable patterns: colour bars, checkerboard, gradient and solid. It replaces the fixed 640x480 1-bit bar generator and the separate sync blocks at the top of the VGA path.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
SYNC_POL, 0, active level of o_hsync/o_vsync (0 = active-low)
CW, 1, bits per colour channel
CNT_W, 12, counter/coordinate width
NUM_BARS, 8, colour-bar count (1..H_ACTIVE)
CHK_LOG2, 5, checker square size = 2^CHK_LOG2 pixels
GRAD_SH, 6, gradient shift: channel = (h >> GRAD_SH) truncated to CW bits

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous active-low reset
i_en  in  1  pixel-enable strobe; all state advances only when high
i_mode  in  2  pattern select: 0 bars, 1 checker, 2 gradient, 3 solid
i_solid  in  3*CW  solid colour {R,G,B} for mode 3
o_hsync  out  1  horizontal sync
o_vsync  out  1  vertical sync
o_blank  out  1  high outside the active area
o_x  out  CNT_W  horizontal counter value of the current output pixel
o_y  out  CNT_W  vertical counter value of the current output pixel
o_frame_start  out  1  one-i_clk pulse coincident with pixel (0,0)
o_red/o_grn/o_blu  out  CW each  pixel colour

Behaviour:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL analogous. Counters h: 0..H_TOTAL-1, v: 0..V_TOTAL-1.
- On an i_clk edge with i_en=1: output registers load values computed from the current (h,v), then h increments. h wraps H_TOTAL-1 -> 0 and v increments. v wraps V_TOTAL-1 -> 0 on the same edge that h wraps. With i_en=0, all counters and outputs hold, except o_frame_start, which clears.
- Latency: every output is exactly one enable-cycle behind the counters. All outputs come from one register stage, so they are mutually aligned.
- Active area: h<H_ACTIVE and v<V_ACTIVE. o_blank = !active.
- hsync asserted for H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC. vsync asserted for V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, for entire lines. Asserted level = SYNC_POL.
- Mode/solid latch: mode_q and solid_q capture i_mode and i_solid on an i_en edge at h=H_TOTAL-1, v=V_TOTAL-1. The new pattern therefore starts at pixel (0,0) and is constant for the whole frame. Mid-frame i_mode changes are ignored until then.
- Bars (mode 0):
  - BAR_W = H_ACTIVE/NUM_BARS (integer division). Use an incremental bar_px/bar_idx counter pair, no divider.
  - Both clear at h=0. bar_idx increments when bar_px reaches BAR_W-1.
  - bar_idx saturates at NUM_BARS-1, so remainder pixels take the last bar.
  - Colour = bar_idx mod 8: bit2 red, bit1 green, bit0 blue. Each channel is all-ones or all-zeros across CW bits.
- Checker (mode 1): white (all ones) when h[CHK_LOG2]^v[CHK_LOG2] = 1, else black.
- Gradient (mode 2): all three channels = (h >> GRAD_SH) low CW bits.
- Solid (mode 3): {R,G,B} = solid_q.
- Blanking: RGB forced to 0 whenever o_blank=1, regardless of mode.
- Reset (async, any time, including mid-frame):
  - Counters, bar counters, mode_q and solid_q clear to 0.
  - o_hsync/o_vsync = !SYNC_POL; o_blank=1; o_x=o_y=0; o_frame_start=0; RGB=0.
  - After release, the first i_en outputs pixel (0,0) with o_frame_start=1 and mode_q=0.

Test Plan:
- Reset mid-line (h=300, v=100), release, i_en held high -> first output x=0,y=0, o_frame_start=1 for 1 clk, RGB per mode 0; o_hsync=1, o_vsync=1 during reset.
- Default timing, i_en every 2nd clk -> 800 enables per line, 525 lines per frame. o_hsync low for x=656..751, o_vsync low for y=490..491, o_blank high for x>=640 or y>=480.
- Mode 0 defaults -> RGB 000 for x=0..79, 001 at x=80, 100 at x=320, 111 for x=560..639, 000 at x=640 (blank).
- NUM_BARS=6 -> BAR_W=106. Bar 5 covers x=530..639, colour 101; no bar index 6 appears.
- Change i_mode 0->3 with i_solid=3'b010 at y=200 -> bars continue to end of frame. Next frame all active pixels are 010, and x=0,y=0 is already 010.
- Mode 1, CHK_LOG2=5 -> (0,0)=000, (32,0)=111, (32,32)=000. Hold i_en low for 10 clks mid-line -> outputs frozen, no x skipped.
